mem_arbiter: RTL and testbench

Shares the single 4K×12 main memory between three requesters: the CPU datapath (driven by the instruction sequencer), the front-panel examine/deposit logic, and the data-break (DMA) channel. Fixed priority with an anti-starvation rule, one access in flight at a time, and a req/ack handshake per requester. Sits between the requesters and the synchronous memory array.

---
 rtl/pdp8_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 41 ++++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: word/address widths, memory-owner encoding
// and the memory arbiter state type.
package pdp8_pkg;

  localparam int WORD_W = 12;
  localparam int ADDR_W = 12;

  // Number of back-to-back data-break grants after which a waiting CPU wins.
  localparam logic [1:0] STARVE_LIMIT = 2'd2;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_CPU   = 2'd1,
    OWN_PANEL = 2'd2,
    OWN_DB    = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for a three-requester arbiter.
// Optional feature macro: MEM_ARB_DATABREAK_EN (data-break requester
// and its anti-starvation rule). Without it the order is cpu > panel.
module mem_arb_pick
  import pdp8_pkg::*;
(
  input  logic       cpu_req_i,
  input  logic       pan_req_i,
  input  logic       db_req_i,
  input  logic       running_i,
  input  logic [1:0] db_cnt_i,
  output owner_t     win_o
);

  // Panel is only eligible while the CPU is halted.
  logic pan_ok;
  assign pan_ok = pan_req_i && !running_i;

`ifdef MEM_ARB_DATABREAK_EN
  // Fixed priority db > cpu > panel, except a CPU that has watched two
  // consecutive data-break grants goes first.
  always_comb begin
    win_o = OWN_NONE;
    if (cpu_req_i && (db_cnt_i >= STARVE_LIMIT)) win_o = OWN_CPU;
    else if (db_req_i)                           win_o = OWN_DB;
    else if (cpu_req_i)                          win_o = OWN_CPU;
    else if (pan_ok)                             win_o = OWN_PANEL;
  end
`else
  logic unused_db;
  assign unused_db = db_req_i ^ (^db_cnt_i);

  // Fixed priority cpu > panel.
  always_comb begin
    win_o = OWN_NONE;
    if (cpu_req_i)   win_o = OWN_CPU;
    else if (pan_ok) win_o = OWN_PANEL;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: CPU, front panel and data-break share one
// synchronous memory port, one access in flight (IDLE -> ISSUE -> ACK).
// Optional feature macro: MEM_ARB_DATABREAK_EN enables the data-break
// port; without it the db* inputs are ignored and dbAck stays 0.
module mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = WORD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          running,
  input  logic          cpuReq,
  input  logic          cpuWe,
  input  logic [AW-1:0] cpuAddr,
  input  logic [DW-1:0] cpuWdata,
  input  logic          panReq,
  input  logic          panWe,
  input  logic [AW-1:0] panAddr,
  input  logic [DW-1:0] panWdata,
  input  logic          dbReq,
  input  logic          dbWe,
  input  logic [AW-1:0] dbAddr,
  input  logic [DW-1:0] dbWdata,
  output logic          cpuAck,
  output logic          panAck,
  output logic          dbAck,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memWdata,
  output logic          memWe,
  input  logic [DW-1:0] memRdata,
  output logic [1:0]    owner,
  output logic          busy
);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [DW-1:0] memWdata_q, memWdata_d;
  logic          memWe_q, memWe_d;
  logic [1:0]    dbCnt_q, dbCnt_d;
  owner_t        win;
  logic          dbReqEff;

`ifdef MEM_ARB_DATABREAK_EN
  assign dbReqEff = dbReq;
`else
  logic unused_db;
  assign unused_db = ^{dbReq, dbWe, dbAddr, dbWdata};
  assign dbReqEff  = 1'b0;
`endif

  mem_arb_pick u_pick (
    .cpu_req_i (cpuReq),
    .pan_req_i (panReq),
    .db_req_i  (dbReqEff),
    .running_i (running),
    .db_cnt_i  (dbCnt_q),
    .win_o     (win)
  );

  // Next-state logic: requests are sampled only in IDLE.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memWe_d    = memWe_q;
    dbCnt_d    = dbCnt_q;
    unique case (state_q)
      IDLE: begin
        owner_d = OWN_NONE;
        memWe_d = 1'b0;
        if (win != OWN_NONE) begin
          state_d = ISSUE;
          owner_d = win;
          dbCnt_d = 2'd0;
          unique case (win)
            OWN_CPU: begin
              memAddr_d  = cpuAddr;
              memWdata_d = cpuWdata;
              memWe_d    = cpuWe;
            end
            OWN_PANEL: begin
              memAddr_d  = panAddr;
              memWdata_d = panWdata;
              memWe_d    = panWe;
            end
`ifdef MEM_ARB_DATABREAK_EN
            OWN_DB: begin
              memAddr_d  = dbAddr;
              memWdata_d = dbWdata;
              memWe_d    = dbWe;
              // Saturate: only "two or more in a row" matters.
              dbCnt_d    = (dbCnt_q >= STARVE_LIMIT) ? STARVE_LIMIT : dbCnt_q + 2'd1;
            end
`endif
            default: ;
          endcase
        end
      end
      ISSUE: begin
        memWe_d = 1'b0;
        state_d = ACK;
      end
      ACK: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: begin
        owner_d = OWN_NONE;
        memWe_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and memory-port registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memWe_q    <= 1'b0;
      dbCnt_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWe_q    <= memWe_d;
      dbCnt_q    <= dbCnt_d;
    end
  end

  assign memAddr  = memAddr_q;
  assign memWdata = memWdata_q;
  assign memWe    = memWe_q;
  assign owner    = owner_q;
  assign busy     = (state_q != IDLE);
  assign rdata    = memRdata;
  assign cpuAck   = (state_q == ACK) && (owner_q == OWN_CPU);
  assign panAck   = (state_q == ACK) && (owner_q == OWN_PANEL);
`ifdef MEM_ARB_DATABREAK_EN
  assign dbAck    = (state_q == ACK) && (owner_q == OWN_DB);
`else
  assign dbAck    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected
// (owner, read data) of each access; a negedge monitor pops on every ack.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset, running;
  logic        cpuReq, cpuWe, panReq, panWe, dbReq, dbWe;
  logic [11:0] cpuAddr, cpuWdata, panAddr, panWdata, dbAddr, dbWdata;
  logic        cpuAck, panAck, dbAck, memWe, busy;
  logic [11:0] rdata, memAddr, memWdata, memRdata;
  logic [1:0]  owner;

  int n_chk  = 0;
  int n_fail = 0;
  int cpu_left, pan_left, db_left;

  typedef struct {
    logic [1:0]  own;
    bit          chk_rd;
    logic [11:0] rd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(12), .DW(12)) dut (
    .clk(clk), .reset(reset), .running(running),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .panReq(panReq), .panWe(panWe), .panAddr(panAddr), .panWdata(panWdata),
    .dbReq(dbReq), .dbWe(dbWe), .dbAddr(dbAddr), .dbWdata(dbWdata),
    .cpuAck(cpuAck), .panAck(panAck), .dbAck(dbAck), .rdata(rdata),
    .memAddr(memAddr), .memWdata(memWdata), .memWe(memWe),
    .memRdata(memRdata), .owner(owner), .busy(busy)
  );

  // Initial memory image.
  function automatic logic [11:0] img(input logic [11:0] a);
    return (a == 12'o200) ? 12'o7001 : (a ^ 12'o5252);
  endfunction

  // Synchronous memory model: read data one cycle after the address.
  logic [11:0] mem [0:4095];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) mem[i] <= img(12'(i));
    end else if (memWe) begin
      mem[memAddr] <= memWdata;
    end
    memRdata <= mem[memAddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] own, input bit chk_rd, input logic [11:0] rd);
    exp_t e;
    e.own = own; e.chk_rd = chk_rd; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack must match the oldest expected access.
  always @(negedge clk) begin
    logic [2:0] acks;
    logic [1:0] got;
    exp_t e;
    acks = {dbAck, panAck, cpuAck};
    if (acks != 3'b000) begin
      n_chk++;
      got = dbAck ? 2'd3 : (panAck ? 2'd2 : 2'd1);
      if ($countones(acks) != 1) begin
        n_fail++;
        $display("FAIL ack_onehot: got acks %b expected exactly one", acks);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: got ack from owner %0d expected none", got);
      end else begin
        e = sb.pop_front();
        if (got !== e.own) begin
          n_fail++;
          $display("FAIL ack_owner: got %0d expected %0d", got, e.own);
        end
        if (e.chk_rd) begin
          n_chk++;
          if (rdata !== e.rd) begin
            n_fail++;
            $display("FAIL ack_rdata: got %0o expected %0o", rdata, e.rd);
          end
        end
      end
    end
  end

  // Serve outstanding access counts, dropping each req after its last ack.
  task automatic serve(input string name, input int maxc);
    int c = 0;
    while (((cpu_left + pan_left + db_left) != 0 || busy) && c < maxc) begin
      tick();
      c++;
`ifndef MEM_ARB_DATABREAK_EN
      check("owner_not_db", {30'd0, owner}, (owner == 2'd3) ? 32'd0 : {30'd0, owner});
`endif
      if (cpuAck) begin cpu_left--; if (cpu_left == 0) cpuReq = 1'b0; end
      if (panAck) begin pan_left--; if (pan_left == 0) panReq = 1'b0; end
      if (dbAck)  begin db_left--;  if (db_left == 0)  dbReq  = 1'b0; end
    end
    check({name, "_done"}, {31'd0, (c >= maxc)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; running = 1'b0;
    cpuReq = 0; cpuWe = 0; cpuAddr = 0; cpuWdata = 0;
    panReq = 0; panWe = 0; panAddr = 0; panWdata = 0;
    dbReq = 0; dbWe = 0; dbAddr = 0; dbWdata = 0;
    cpu_left = 0; pan_left = 0; db_left = 0;

    // Reset state
    repeat (3) tick();
    check("rst_cpuAck", cpuAck, 0);
    check("rst_panAck", panAck, 0);
    check("rst_dbAck", dbAck, 0);
    check("rst_memWe", memWe, 0);
    check("rst_memAddr", memAddr, 0);
    check("rst_memWdata", memWdata, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // CPU read of 0o200
    cpuReq = 1; cpuAddr = 12'o200;
    push(2'd1, 1'b1, 12'o7001);
    tick();
    check("rd_memAddr", memAddr, 12'o200);
    check("rd_owner_c1", owner, 1);
    check("rd_busy", busy, 1);
    check("rd_memWe", memWe, 0);
    tick();
    check("rd_cpuAck_c2", cpuAck, 1);
    check("rd_owner_c2", owner, 1);
    check("rd_rdata_c2", rdata, 12'o7001);
    cpuReq = 0;
    tick();
    check("rd_ack_pulse", cpuAck, 0);
    check("rd_owner_idle", owner, 0);
    check("rd_busy_idle", busy, 0);

    // Panel deposit held off while running
    running = 1; panReq = 1; panWe = 1; panAddr = 12'o17; panWdata = 12'o1234;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pan_blocked", {busy, owner}, 0);
    end
    running = 0;
    push(2'd2, 1'b0, 12'o0);
    tick();
    check("pan_memWe", memWe, 1);
    check("pan_memAddr", memAddr, 12'o17);
    check("pan_memWdata", memWdata, 12'o1234);
    check("pan_owner", owner, 2);
    tick();
    check("pan_memWe_off", memWe, 0);
    check("pan_ack", panAck, 1);
    panReq = 0; panWe = 0;
    tick();
    check("pan_written", mem[12'o17], 12'o1234);

    // CPU and panel together: cpu first, then panel
    cpuReq = 1; cpuAddr = 12'o310; panReq = 1; panAddr = 12'o7777;
    cpu_left = 1; pan_left = 1;
    push(2'd1, 1'b1, img(12'o310));
    push(2'd2, 1'b1, img(12'o7777));
    serve("cpu_pan", 20);

`ifdef MEM_ARB_DATABREAK_EN
    // Three-way contention: db, cpu, panel
    dbReq = 1; dbAddr = 12'o600; cpuReq = 1; cpuAddr = 12'o601;
    panReq = 1; panAddr = 12'o602;
    db_left = 1; cpu_left = 1; pan_left = 1;
    push(2'd3, 1'b1, img(12'o600));
    push(2'd1, 1'b1, img(12'o601));
    push(2'd2, 1'b1, img(12'o602));
    serve("three_way", 30);

    // Anti-starvation: db, db, cpu, db, db, cpu
    dbReq = 1; dbAddr = 12'o4000; cpuReq = 1; cpuAddr = 12'o4001;
    db_left = 4; cpu_left = 2;
    push(2'd3, 1'b1, img(12'o4000));
    push(2'd3, 1'b1, img(12'o4000));
    push(2'd1, 1'b1, img(12'o4001));
    push(2'd3, 1'b1, img(12'o4000));
    push(2'd3, 1'b1, img(12'o4000));
    push(2'd1, 1'b1, img(12'o4001));
    serve("starve", 40);
`else
    // Data-break ignored: only the CPU is served
    dbReq = 1; dbWe = 1; dbAddr = 12'o500; dbWdata = 12'o7777;
    cpuReq = 1; cpuAddr = 12'o300;
    cpu_left = 2;
    push(2'd1, 1'b1, img(12'o300));
    push(2'd1, 1'b1, img(12'o300));
    serve("db_ignored", 20);
    check("db_not_written", mem[12'o500], img(12'o500));
    dbReq = 0; dbWe = 0;
`endif

    // Reset during ISSUE of a CPU write aborts it
    cpuReq = 1; cpuWe = 1; cpuAddr = 12'o400; cpuWdata = 12'o55;
    tick();
    check("rsti_memWe", memWe, 1);
    reset = 1;
    tick();
    check("rsti_cpuAck", cpuAck, 0);
    check("rsti_memWe_off", memWe, 0);
    check("rsti_owner", owner, 0);
    check("rsti_busy", busy, 0);
    reset = 0;
    push(2'd1, 1'b0, 12'o0);
    tick();
    check("rsti_reissue_addr", memAddr, 12'o400);
    tick();
    check("rsti_ack", cpuAck, 1);
    cpuReq = 0; cpuWe = 0;
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
